piano_synth: RTL and testbench
==============================

Name: piano_synth

Overview:
- Parametrised successor to the fixed four-key tone piano.
- Generates a square-wave tone from NUM_KEYS debounced key inputs using one shared reloadable divider, rather than one free-running timer per note.
- Adds an octave shift, a registered note/active status and glitch-controlled note changes.
- Sits between the board push-buttons and the speaker pin.

Parameters:
- NUM_KEYS, 4, number of key inputs; key k sounds one octave above key k-1.
- CNT_W, 16, divider counter width; BASE_HALF_PERIOD must fit in CNT_W bits.
- BASE_HALF_PERIOD, 25000, half-period in i_clk cycles of key 0 at octave 0.
- DEB_CYCLES, 1000, consecutive stable cycles required before a key state change is accepted; minimum 1.
- OCT_W, 2, width of the octave select input.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset; deassertion synchronous to i_clk externally
- i_keys  input  NUM_KEYS  raw asynchronous key levels, 1 = pressed
- i_octave  input  OCT_W  octave shift, sampled synchronously; higher value = higher pitch
- o_speaker  output  1  square-wave tone, 0 when silent
- o_active  output  1  1 while a note is sounding
- o_note  output  clog2(NUM_KEYS) (min 1)  index of the sounding key; 0 when inactive

Behaviour:
- Reset (i_reset_n = 0, asynchronous):
  - o_speaker = 0, o_active = 0, o_note = 0.
  - Synchronisers, debounce counters, stable key states, divider counter and registered octave all cleared.
- Synchronisation: each i_keys bit passes through 2 flops before debounce.
- Debounce, per key:
  - Counter increments while the synchronised level differs from the stable state; it clears when they match.
  - When the counter reaches DEB_CYCLES, the stable state takes the synchronised level and the counter clears.
  - A level pulse shorter than DEB_CYCLES cycles never changes the stable state.
- Selection, registered:
  - The lowest-index stable pressed key wins.
  - If no key is pressed, sel_valid = 0.
  - o_note and o_active are updated from the selection one cycle after the stable state changes.
- Latency: a clean key press sampled at edge 0 gives o_active = 1 at edge 3 + DEB_CYCLES.
- Half-period computation:
  - half = BASE_HALF_PERIOD >> (o_note + octave_reg).
  - If the shift gives 0, half is clamped to 1.
  - octave_reg is i_octave registered once.
- Divider, only while o_active = 1:
  - Counter counts 0 .. half-1.
  - At half-1 it toggles o_speaker and returns to 0.
  - Result: period = 2*half cycles, 50% duty.
- Note change: a change of o_note or octave_reg while active clears the counter. o_speaker keeps its current level, so the first new half-period is complete (no runt pulse).
- Activation: o_active 0->1 clears the counter with o_speaker = 0; first rising edge of o_speaker occurs half cycles after o_active rises.
- Release: o_active 1->0 forces o_speaker = 0 and clears the counter on the same edge.
- Simultaneous events:
  - A higher-priority press while a lower key sounds switches the note per the note-change rule.
  - Releasing the winning key while another stays pressed switches the note without going silent.
  - A note change and an octave change on the same edge are treated as a single change.
- Reset mid-tone: all state clears immediately; after release a held key requires a full debounce again.

Test Plan:
- Overrides BASE_HALF_PERIOD=8, DEB_CYCLES=4, NUM_KEYS=4. Reset with key 0 held, then release reset -> o_active rises exactly 7 edges after reset release; o_speaker first rises 8 cycles after o_active; period 16 cycles, 50% duty.
- Press key 2 only, octave 0 -> o_note=2, period 4 cycles. Set octave=1 -> period 2 cycles. Set octave=3 -> half clamped to 1, period 2 cycles.
- 3-cycle glitch on key 1 -> o_active stays 0, o_speaker stays 0 throughout.
- Key 3 sounding, then press key 0 -> o_note switches to 0. Speaker level is held across the switch; next toggle occurs exactly 8 cycles after o_note changes.
- Key 0 and key 1 held, release key 0 -> o_note goes to 1, o_active never drops. Release key 1 -> o_speaker = 0 and o_active = 0 on the same edge.
- Assert i_reset_n = 0 mid-tone, asynchronously between edges -> outputs go to 0 without a clock edge. After release, held key gives o_active again only after the full 7-edge latency.

Source files
------------

// File: rtl/piano_synth.sv
`default_nettype none
// ============================================================================
// piano_synth : debounced keys select a note; one shared reloadable divider
//               produces the square-wave tone.                      Rev 1.0
// ============================================================================
module piano_synth #(
    parameter int  NUM_KEYS         = 4,
    parameter int  CNT_W            = 16,
    parameter int  BASE_HALF_PERIOD = 25000,
    parameter int  DEB_CYCLES       = 1000,
    parameter int  OCT_W            = 2,
    localparam int NOTE_W           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [NUM_KEYS-1:0] i_keys,
    input  logic [OCT_W-1:0]    i_octave,
    output logic                o_speaker,
    output logic                o_active,
    output logic [NOTE_W-1:0]   o_note
);
    localparam int                DCNT_W    = $clog2(DEB_CYCLES + 1);
    localparam int                SH_W      = NOTE_W + OCT_W + 1;
    localparam logic [DCNT_W-1:0] DEB_LIMIT = DCNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  BASE_HALF = CNT_W'(BASE_HALF_PERIOD);

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] stable_w;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_keys;
            sync2_q <= sync1_q;
        end
    end

    // A change is accepted only after the counter has seen DEB_CYCLES
    // differing samples and the level still differs on the following edge.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
        logic [DCNT_W-1:0] cnt_q;
        logic              stable_q;

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else if (sync2_q[k] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LIMIT) begin
                stable_q <= sync2_q[k];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + DCNT_W'(1);
            end
        end

        assign stable_w[k] = stable_q;
    end

    logic              active_d;
    logic [NOTE_W-1:0] note_d;

    always_comb begin
        active_d = 1'b0;
        note_d   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (stable_w[i]) begin
                active_d = 1'b1;
                note_d   = NOTE_W'(i);
            end
        end
    end

    logic [OCT_W-1:0]  octave_q;
    logic              active_q;
    logic [NOTE_W-1:0] note_q;
    logic              spk_q;
    logic [CNT_W-1:0]  div_cnt_q;

    logic [SH_W-1:0]   shift_w;
    logic [CNT_W-1:0]  shifted_w;
    logic [CNT_W-1:0]  half_w;
    logic              retune_w;

    assign shift_w   = SH_W'(note_q) + SH_W'(octave_q);
    assign shifted_w = BASE_HALF >> shift_w;
    assign half_w    = (shifted_w == '0) ? CNT_W'(1) : shifted_w;
    assign retune_w  = (note_d != note_q) || (i_octave != octave_q);

    // Retuning restarts the count but keeps the speaker level, so the first
    // half-period at the new pitch is always a full one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            octave_q  <= '0;
            active_q  <= 1'b0;
            note_q    <= '0;
            spk_q     <= 1'b0;
            div_cnt_q <= '0;
        end else begin
            octave_q <= i_octave;
            active_q <= active_d;
            note_q   <= note_d;
            if (!active_d || !active_q) begin
                spk_q     <= 1'b0;
                div_cnt_q <= '0;
            end else if (retune_w) begin
                div_cnt_q <= '0;
            end else if (div_cnt_q == half_w - CNT_W'(1)) begin
                spk_q     <= ~spk_q;
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_speaker = spk_q;
    assign o_active  = active_q;
    assign o_note    = note_q;

endmodule
`default_nettype wire

// File: tb/tb_piano_synth.sv
`default_nettype none
// ============================================================================
// tb_piano_synth : directed scenarios plus randomized key/octave traffic
//                  against a behavioural model.                     Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_piano_synth;
    localparam int NK    = 4;
    localparam int BASE  = 8;
    localparam int DEB   = 4;
    localparam int OCT_W = 2;
    localparam int NW    = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [NK-1:0]    keys  = '0;
    logic [OCT_W-1:0] oct   = '0;
    logic             spk;
    logic             act;
    logic [NW-1:0]    note;

    piano_synth #(
        .NUM_KEYS(NK), .CNT_W(16), .BASE_HALF_PERIOD(BASE),
        .DEB_CYCLES(DEB), .OCT_W(OCT_W)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_keys(keys), .i_octave(oct),
        .o_speaker(spk), .o_active(act), .o_note(note)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: raw key history, per-key stable level, and the
    // current tone segment (start edge + starting level).
    logic [NK-1:0] hist[$];
    int            m_n;
    logic [NK-1:0] m_stable;
    int            last_chg[NK];
    bit            m_active;
    bit            m_spk;
    int            m_note;
    int            m_oct;
    int            seg_start;
    bit            seg_level;

    function automatic void model_reset();
        hist.delete();
        m_n = 0; m_stable = '0; m_active = 0; m_spk = 0;
        m_note = 0; m_oct = 0; seg_start = 0; seg_level = 0;
        for (int i = 0; i < NK; i++) last_chg[i] = -1;
    endfunction

    function automatic logic [NK-1:0] sync_at(input int j);
        return (j >= 2) ? hist[j-2] : '0;
    endfunction

    function automatic int half_of(input int n, input int o);
        int h;
        h = BASE >> (n + o);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic step();
        logic [NK-1:0] k;
        logic [NK-1:0] s;
        int            o;
        bit            new_act;
        int            new_note;
        bit            flip;
        k = keys;
        o = int'(oct);
        @(posedge clk);
        hist.push_back(k);
        new_act  = |m_stable;
        new_note = 0;
        for (int i = NK - 1; i >= 0; i--) if (m_stable[i]) new_note = i;
        if (new_act && !m_active) begin
            seg_start = m_n; seg_level = 0;
        end else if (new_act && (new_note != m_note || o != m_oct)) begin
            seg_start = m_n; seg_level = m_spk;
        end
        m_active = new_act; m_note = new_note; m_oct = o;
        m_spk = new_act ? (seg_level ^ (((m_n - seg_start) / half_of(m_note, m_oct)) % 2 == 1)) : 1'b0;
        for (int i = 0; i < NK; i++) begin
            if (m_n - DEB > last_chg[i]) begin
                flip = 1;
                for (int j = m_n - DEB; j <= m_n; j++) begin
                    s = sync_at(j);
                    if (s[i] == m_stable[i]) flip = 0;
                end
                if (flip) begin
                    m_stable[i] = ~m_stable[i];
                    last_chg[i] = m_n;
                end
            end
        end
        m_n++;
        #1;
    endtask

    task automatic wait_act(input bit target, output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (act === target) ok = 1;
        end
    endtask

    task automatic measure(output int hi, output int lo);
        int t;
        t = 0; hi = -1; lo = -1;
        while (spk !== 1'b0 && t < 100) begin step(); t++; end
        while (spk !== 1'b1 && t < 100) begin step(); t++; end
        if (t >= 100) return;
        hi = 0;
        while (spk === 1'b1 && hi < 100) begin step(); hi++; end
        lo = 0;
        while (spk === 1'b0 && lo < 100) begin step(); lo++; end
    endtask

    task automatic test_reset();
        int t, hi, lo;
        keys = 4'b0001; oct = '0; rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({act, spk, note} !== 4'b0) begin
            failures++; $display("FAIL reset_outputs: act=%b spk=%b note=%0d want 0/0/0", act, spk, note);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            step();
            checks++;
            if (act !== (e == 7)) begin
                failures++; $display("FAIL latency edge %0d: act=%b want %b", e, act, (e == 7));
            end
        end
        checks++;
        if (note !== 2'd0) begin failures++; $display("FAIL reset_note: note=%0d want 0", note); end
        t = 0;
        while (spk !== 1'b1 && t < 40) begin step(); t++; end
        checks++;
        if (t !== 8) begin failures++; $display("FAIL first_rise: %0d cycles want 8", t); end
        measure(hi, lo);
        checks++;
        if (hi !== 8 || lo !== 8) begin failures++; $display("FAIL key0_period: hi=%0d lo=%0d want 8/8", hi, lo); end
    endtask

    task automatic test_octave();
        bit ok;
        int hi, lo;
        keys = '0;
        wait_act(1'b0, ok);
        keys = 4'b0100; oct = 2'd0;
        wait_act(1'b1, ok);
        checks++;
        if (!ok || note !== 2'd2) begin failures++; $display("FAIL key2_note: act=%b note=%0d want 1/2", act, note); end
        measure(hi, lo);
        checks++;
        if (hi !== 2 || lo !== 2) begin failures++; $display("FAIL oct0_period: hi=%0d lo=%0d want 2/2", hi, lo); end
        oct = 2'd1; repeat (2) step();
        measure(hi, lo);
        checks++;
        if (hi !== 1 || lo !== 1) begin failures++; $display("FAIL oct1_period: hi=%0d lo=%0d want 1/1", hi, lo); end
        oct = 2'd3; repeat (2) step();
        measure(hi, lo);
        checks++;
        if (hi !== 1 || lo !== 1) begin failures++; $display("FAIL oct3_clamp: hi=%0d lo=%0d want 1/1", hi, lo); end
        oct = 2'd0;
    endtask

    task automatic test_glitch();
        bit ok;
        keys = '0;
        wait_act(1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL glitch_idle: act=%b want 0", act); end
        keys = 4'b0010;
        repeat (3) step();
        keys = '0;
        for (int e = 0; e < 20; e++) begin
            step();
            checks++;
            if (act !== 1'b0 || spk !== 1'b0) begin
                failures++; $display("FAIL glitch edge %0d: act=%b spk=%b want 0/0", e, act, spk);
            end
        end
    endtask

    task automatic test_switch();
        bit   ok;
        int   t;
        logic lvl;
        keys = 4'b1000;
        wait_act(1'b1, ok);
        checks++;
        if (!ok || note !== 2'd3) begin failures++; $display("FAIL key3_note: act=%b note=%0d want 1/3", act, note); end
        repeat (5) step();
        keys = 4'b1001;
        t = 0;
        while (note !== 2'd0 && t < 30) begin step(); t++; end
        checks++;
        if (note !== 2'd0) begin failures++; $display("FAIL switch_note: note=%0d want 0", note); end
        lvl = spk;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (spk !== ((e < 8) ? lvl : ~lvl)) begin
                failures++; $display("FAIL switch_hold edge %0d: spk=%b want %b", e, spk, (e < 8) ? lvl : ~lvl);
            end
        end
    endtask

    task automatic test_release();
        bit ok, dropped;
        int t;
        keys = '0;
        wait_act(1'b0, ok);
        keys = 4'b0011;
        wait_act(1'b1, ok);
        checks++;
        if (!ok || note !== 2'd0) begin failures++; $display("FAIL pair_note: act=%b note=%0d want 1/0", act, note); end
        repeat (3) step();
        keys = 4'b0010;
        dropped = 0; t = 0;
        while (note !== 2'd1 && t < 30) begin
            step(); t++;
            if (act !== 1'b1) dropped = 1;
        end
        checks++;
        if (note !== 2'd1 || dropped) begin failures++; $display("FAIL handover: note=%0d dropped=%b want 1/0", note, dropped); end
        repeat (3) step();
        keys = '0;
        t = 0;
        while (act !== 1'b0 && t < 30) begin step(); t++; end
        checks++;
        if (act !== 1'b0 || spk !== 1'b0) begin failures++; $display("FAIL release: act=%b spk=%b want 0/0", act, spk); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int t;
        keys = 4'b0001;
        wait_act(1'b1, ok);
        t = 0;
        while (spk !== 1'b1 && t < 40) begin step(); t++; end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({act, spk, note} !== 4'b0) begin
            failures++; $display("FAIL async_reset: act=%b spk=%b note=%0d want 0/0/0", act, spk, note);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            step();
            checks++;
            if (act !== (e == 7)) begin
                failures++; $display("FAIL relatch edge %0d: act=%b want %b", e, act, (e == 7));
            end
        end
    endtask

    task automatic test_random();
        int edges, hold;
        edges = 0;
        while (edges < 1500) begin
            keys = NK'($urandom_range(0, (1 << NK) - 1));
            if ($urandom_range(0, 3) == 0) oct = OCT_W'($urandom_range(0, 3));
            hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
            for (int e = 0; e < hold; e++) begin
                step(); edges++;
                checks++;
                if ({act, note, spk} !== {m_active, NW'(m_note), m_spk}) begin
                    failures++;
                    $display("FAIL random edge %0d: act/note/spk=%b/%0d/%b want %b/%0d/%b",
                             m_n - 1, act, note, spk, m_active, m_note, m_spk);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_octave();
        test_glitch();
        test_switch();
        test_release();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
